// File: rtl/qs_srt_ucode_fetch.sv
// Microcode fetch/sequencer stage for the quicksort engine: owns the PC, drives the
// ucode ROM address and holds one fetched word behind a valid/ready handshake.
module qs_srt_ucode_fetch #(
  parameter int PC_W     = 8,
  parameter int INST_W   = 16,
  parameter int RESET_PC = 0,
  parameter int ERR_PC   = 128,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   ra,
  input  logic [INST_W-1:0] rin,
  input  logic              redirect_vld_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              fetch_vld_o,
  output logic [INST_W-1:0] fetch_inst_o,
  output logic [PC_W-1:0]   fetch_pc_o,
  input  logic              fetch_rdy_i,
  output logic              err_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] LP_ERR_PC   = PC_W'(ERR_PC);

  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_fetchPc;
  logic [INST_W-1:0] r_fetchInst;
  logic              r_fetchVld;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_xfer;
  logic              w_load;
  logic [PC_W-1:0]   w_ra;

  // A redirect makes the held word wrong-path, so it never counts as accepted.
  assign w_xfer = r_fetchVld & fetch_rdy_i & ~redirect_vld_i;
  assign w_load = redirect_vld_i | ~r_fetchVld | w_xfer;
  assign w_ra   = redirect_vld_i ? redirect_pc_i : r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= LP_RESET_PC;
      r_fetchPc   <= '0;
      r_fetchInst <= '0;
      r_fetchVld  <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_load) begin
        r_fetchInst <= rin;
        r_fetchPc   <= w_ra;
        r_fetchVld  <= 1'b1;
        r_pc        <= w_ra + PC_W'(1);
        if (w_ra == LP_ERR_PC) begin
          r_err <= 1'b1;
        end
      end
      if (w_xfer && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ra           = w_ra;
  assign fetch_vld_o  = r_fetchVld;
  assign fetch_inst_o = r_fetchInst;
  assign fetch_pc_o   = r_fetchPc;
  assign err_o        = r_err;
  assign fetch_cnt_o  = r_cnt;

endmodule

// File: tb/tb_qs_srt_ucode_fetch.sv
// Directed scoreboard bench for qs_srt_ucode_fetch: expected fetch state is queued as
// each step is driven and compared after the clock edge that produces it.
module tb_qs_srt_ucode_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  ra;
  logic [15:0] rin;
  logic        redirVld;
  logic [7:0]  redirPc;
  logic        fetchVld;
  logic [15:0] fetchInst;
  logic [7:0]  fetchPc;
  logic        fetchRdy;
  logic        errFlag;
  logic [31:0] fetchCnt;

  logic        satRst;
  logic [7:0]  satRa;
  logic [15:0] satRin;
  logic        satRedirVld;
  logic [7:0]  satRedirPc;
  logic        satVld;
  logic [15:0] satInst;
  logic [7:0]  satPc;
  logic        satRdy;
  logic        satErr;
  logic [2:0]  satCnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        vld;
    logic [7:0]  pc;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  exp_t sbQ[$];

  function automatic logic [15:0] romWord(input logic [7:0] addr);
    return {addr ^ 8'h5A, ~addr};
  endfunction

  assign rin    = romWord(ra);
  assign satRin = romWord(satRa);

  qs_srt_ucode_fetch dut (
    .clk(clk), .rst(rst), .ra(ra), .rin(rin),
    .redirect_vld_i(redirVld), .redirect_pc_i(redirPc),
    .fetch_vld_o(fetchVld), .fetch_inst_o(fetchInst), .fetch_pc_o(fetchPc),
    .fetch_rdy_i(fetchRdy), .err_o(errFlag), .fetch_cnt_o(fetchCnt)
  );

  // Narrow counter instance so saturation is reachable in a handful of cycles.
  qs_srt_ucode_fetch #(.CNT_W(3)) satDut (
    .clk(clk), .rst(satRst), .ra(satRa), .rin(satRin),
    .redirect_vld_i(satRedirVld), .redirect_pc_i(satRedirPc),
    .fetch_vld_o(satVld), .fetch_inst_o(satInst), .fetch_pc_o(satPc),
    .fetch_rdy_i(satRdy), .err_o(satErr), .fetch_cnt_o(satCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: observed=empty scoreboard expected=entry", tag);
      return;
    end
    e = sbQ.pop_front();
    checkVal({tag, ".vld"}, 64'(fetchVld), 64'(e.vld));
    checkVal({tag, ".pc"}, 64'(fetchPc), 64'(e.vld ? e.pc : 8'h00));
    checkVal({tag, ".inst"}, 64'(fetchInst), 64'(e.vld ? romWord(e.pc) : 16'h0000));
    checkVal({tag, ".cnt"}, 64'(fetchCnt), 64'(e.cnt));
    checkVal({tag, ".err"}, 64'(errFlag), 64'(e.err));
  endtask

  task automatic applyStimulus(input string tag, input logic rstV, input logic redirV,
                               input logic [7:0] target, input logic rdyV,
                               input logic expVld, input logic [7:0] expPc,
                               input logic [31:0] expCnt, input logic expErr);
    exp_t e;
    rst      = rstV;
    redirVld = redirV;
    redirPc  = target;
    fetchRdy = rdyV;
    e.vld = expVld;
    e.pc  = expPc;
    e.cnt = expCnt;
    e.err = expErr;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; redirVld = 1'b0; redirPc = 8'h00; fetchRdy = 1'b0;
    satRst = 1'b1; satRedirVld = 1'b0; satRedirPc = 8'h00; satRdy = 1'b0;

    // Reset held three cycles, then streaming with a redirect to 96.
    for (int i = 0; i < 3; i++) applyStimulus("rst", 1, 0, 8'd0, 0, 0, 8'd0, 0, 0);
    #1;
    checkVal("rst.ra", 64'(ra), 64'd0);
    applyStimulus("t1.first", 0, 0, 8'd0,  1, 1, 8'd0,  0, 0);
    applyStimulus("t1.seq",   0, 0, 8'd0,  1, 1, 8'd1,  1, 0);
    applyStimulus("t1.redir", 0, 1, 8'd96, 1, 1, 8'd96, 1, 0);
    applyStimulus("t1.97",    0, 0, 8'd0,  1, 1, 8'd97, 2, 0);
    applyStimulus("t1.98",    0, 0, 8'd0,  1, 1, 8'd98, 3, 0);

    // Stall at pc 5 for three cycles, then release.
    applyStimulus("t2.to5", 0, 1, 8'd5, 1, 1, 8'd5, 3, 0);
    for (int i = 0; i < 3; i++) applyStimulus("t2.stall", 0, 0, 8'd0, 0, 1, 8'd5, 3, 0);
    applyStimulus("t2.pc6", 0, 0, 8'd0, 1, 1, 8'd6, 4, 0);
    applyStimulus("t2.pc7", 0, 0, 8'd0, 1, 1, 8'd7, 5, 0);

    // Redirect while rdy=1 must not count the wrong-path word.
    applyStimulus("t3.to10", 0, 1, 8'd10, 1, 1, 8'd10, 5, 0);
    redirVld = 1'b1; redirPc = 8'd64; #1;
    checkVal("t3.ra", 64'(ra), 64'd64);
    applyStimulus("t3.to64", 0, 1, 8'd64, 1, 1, 8'd64, 5, 0);
    applyStimulus("t3.pc65", 0, 0, 8'd0,  1, 1, 8'd65, 6, 0);

    // PC wrap from 255.
    applyStimulus("t4.255", 0, 1, 8'd255, 1, 1, 8'd255, 6, 0);
    applyStimulus("t4.0",   0, 0, 8'd0,   1, 1, 8'd0,   7, 0);
    applyStimulus("t4.1",   0, 0, 8'd0,   1, 1, 8'd1,   8, 0);

    // Error vector is sticky; redirect to current pc_r refetches; redirect in stall.
    applyStimulus("t5.err",    0, 1, 8'd128, 1, 1, 8'd128, 8, 1);
    applyStimulus("t5.to0",    0, 1, 8'd0,   1, 1, 8'd0,   8, 1);
    applyStimulus("t5.samepc", 0, 1, 8'd1,   1, 1, 8'd1,   8, 1);
    applyStimulus("t5.pc2",    0, 0, 8'd0,   1, 1, 8'd2,   9, 1);
    applyStimulus("t5.stall",  0, 0, 8'd0,   0, 1, 8'd2,   9, 1);
    applyStimulus("t5.stRedir",0, 1, 8'd20,  0, 1, 8'd20,  9, 1);
    applyStimulus("t5.hold20", 0, 0, 8'd0,   0, 1, 8'd20,  9, 1);

    // Reset wins over redirect and handshake.
    applyStimulus("t6.rst", 1, 1, 8'd50, 1, 0, 8'd0, 0, 0);
    redirVld = 1'b0; #1;
    checkVal("t6.ra", 64'(ra), 64'd0);
    applyStimulus("t6.first", 0, 0, 8'd0, 1, 1, 8'd0, 0, 0);
    applyStimulus("t6.pc1",   0, 0, 8'd0, 1, 1, 8'd1, 1, 0);

    // 3-bit counter saturates at 7 under sustained rdy.
    satRst = 1'b1; satRdy = 1'b1;
    @(posedge clk); #1;
    checkVal("sat.rst", 64'(satCnt), 64'd0);
    satRst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      checkVal("sat.cnt", 64'(satCnt), 64'((i < 7) ? i : 7));
    end
    checkVal("sat.pc", 64'(satPc), 64'd10);

    $display("[TB] directed sequence complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
